// File: rtl/debug_packer_pkg.sv
// Shared definitions for the debug packer family: packing-order codes and a
// constant-evaluable ceil(log2) used to size chunk counters.
package debug_packer_pkg;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } order_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/debug_packer_if.sv
// Chunk-in / word-out handshake bundle for debug_packer.
interface debug_packer_if
  import debug_packer_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int N    = 8
);
  localparam int OUT_W = IN_W * N;
  localparam int CW    = clog2(N + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic [15:0]      words_out;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, words_out
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, words_out
  );

endinterface

// File: rtl/debug_out_stage.sv
// Generic one-entry valid/ready holding register; load is only legal when
// out_free is high.
module debug_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_free
);

  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_packer.sv
// Packs N IN_W-bit chunks into one word with selectable order, explicit
// flush of partial words and a back-pressured one-word output stage.
module debug_packer
  import debug_packer_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           n_rst,
  debug_packer_if.slave bus
);

  localparam int OUT_W = IN_W * N;
  localparam int CW    = clog2(N + 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  logic [OUT_W-1:0] acc_q, acc_d, acc_m;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_m;
  logic             pend_q, pend_d;
  logic             out_free, full, accept, wrap, flush_act, transfer;
  logic [15:0]      words_cnt;
  logic [CW+OUT_W-1:0] stage_q;

  function automatic logic [OUT_W-1:0] put(input logic [OUT_W-1:0] w,
                                           input logic [CW-1:0]    idx,
                                           input logic [IN_W-1:0]  d);
    int unsigned slot;
    slot = (LSB_FIRST == ORDER_LSB_FIRST) ? 32'(idx) : 32'(N - 1) - 32'(idx);
    for (int unsigned j = 0; j < N; j++) begin
      if (j == slot) w[j*IN_W +: IN_W] = d;
    end
    return w;
  endfunction

  assign full         = (cnt_q == FULL);
  assign bus.in_ready = !full || out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wrap         = accept && full;
  assign flush_act    = bus.flush || pend_q;

  // acc_m/cnt_m fold in a same-cycle chunk; when the accumulator is already
  // full that chunk instead seeds the fresh word after transfer.
  always_comb begin
    acc_m = acc_q;
    cnt_m = cnt_q;
    if (accept && !full) begin
      acc_m = put(acc_q, cnt_q, bus.in_data);
      cnt_m = cnt_q + 1'b1;
    end

    transfer = out_free && ((cnt_m == FULL) || (flush_act && (cnt_m != '0)));

    acc_d  = acc_m;
    cnt_d  = cnt_m;
    pend_d = pend_q || (bus.flush && (cnt_m != '0));
    if (transfer) begin
      acc_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
      if (wrap) begin
        acc_d = put('0, '0, bus.in_data);
        cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      words_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      words_cnt <= words_cnt + 16'd1;
    end
  end

  debug_out_stage #(
    .W(CW + OUT_W)
  ) u_out_stage (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (transfer),
    .load_data({cnt_m, acc_m}),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_data (stage_q),
    .out_free (out_free)
  );

  assign {bus.out_count, bus.out_data} = stage_q;
  assign bus.words_out = words_cnt;

endmodule

// File: tb/tb_debug_packer.sv
// Scoreboard bench: an MSB-first and an LSB-first packer share one stimulus
// stream; expected words are queued as chunks are sent and popped on handoff.
module tb_debug_packer;
  import debug_packer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       flush;
  logic       out_ready;

  debug_packer_if #(.IN_W(4), .N(8)) bm ();
  debug_packer_if #(.IN_W(4), .N(8)) bl ();

  assign bm.in_valid  = in_valid;
  assign bm.in_data   = in_data;
  assign bm.flush     = flush;
  assign bm.out_ready = out_ready;
  assign bl.in_valid  = in_valid;
  assign bl.in_data   = in_data;
  assign bl.flush     = flush;
  assign bl.out_ready = out_ready;

  debug_packer #(.IN_W(4), .N(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .n_rst(n_rst), .bus(bm.slave)
  );
  debug_packer #(.IN_W(4), .N(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .n_rst(n_rst), .bus(bl.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [35:0] qm[$];
  logic [35:0] ql[$];
  logic [3:0]  sent[$];
  logic [15:0] exp_words = '0;

  always @(negedge clk) begin : monitor
    logic [35:0] e;
    if (n_rst === 1'b1 && bm.out_valid === 1'b1 && bm.out_ready === 1'b1) begin
      checks++;
      if (qm.size() == 0) begin
        errors++;
        $display("FAIL msb_unexpected_word got %h_%h want none", bm.out_count, bm.out_data);
      end else begin
        e = qm.pop_front();
        if ({bm.out_count, bm.out_data} !== e) begin
          errors++;
          $display("FAIL msb_word got %h_%h want %h_%h", bm.out_count, bm.out_data, e[35:32], e[31:0]);
        end
      end
    end
    if (n_rst === 1'b1 && bl.out_valid === 1'b1 && bl.out_ready === 1'b1) begin
      checks++;
      if (ql.size() == 0) begin
        errors++;
        $display("FAIL lsb_unexpected_word got %h_%h want none", bl.out_count, bl.out_data);
      end else begin
        e = ql.pop_front();
        if ({bl.out_count, bl.out_data} !== e) begin
          errors++;
          $display("FAIL lsb_word got %h_%h want %h_%h", bl.out_count, bl.out_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one chunk until accepted (bounded); returns cycles spent.
  task automatic send(input logic [3:0] d, input logic fl, output int cycles);
    logic rdy;
    cycles   = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    do begin
      @(negedge clk);
      rdy = bm.in_ready;
      cycle();
      cycles++;
    end while (!rdy && cycles < 50);
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = 4'($urandom);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout got in_ready=0 want accept within 50 cycles");
    end else begin
      sent.push_back(d);
    end
  endtask

  // Build expected words for both orders from the oldest n sent chunks.
  task automatic expect_word(input int n);
    logic [31:0] wm, wl;
    logic [3:0]  c;
    wm = '0;
    wl = '0;
    for (int i = 0; i < n; i++) begin
      c = sent.pop_front();
      wm[(7-i)*4 +: 4] = c;
      wl[i*4 +: 4]     = c;
    end
    qm.push_back({4'(n), wm});
    ql.push_back({4'(n), wl});
    exp_words = exp_words + 16'd1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qm.size() != 0 || ql.size() != 0) && t < 100) begin
      cycle();
      t++;
    end
    cycle();
    checks++;
    if (qm.size() != 0 || ql.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d/%0d words outstanding want 0", qm.size(), ql.size());
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b1; out_ready = 1'b0;
    repeat (3) cycle();
    n_rst = 1'b1;
    flush = 1'b0;
    checks++;
    if (bm.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bm.out_valid); end
    checks++;
    if (bm.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", bm.out_data); end
    checks++;
    if (bm.out_count !== 4'h0) begin errors++; $display("FAIL rst_out_count got %h want 0", bm.out_count); end
    checks++;
    if (bm.words_out !== 16'h0) begin errors++; $display("FAIL rst_words_out got %h want 0", bm.words_out); end
    checks++;
    if (bm.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bm.in_ready); end
    checks++;
    if ({bl.out_valid, bl.out_data, bl.out_count, bl.words_out, bl.in_ready} !== {1'b0, 32'h0, 4'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_lsb got v=%b d=%h c=%h w=%h r=%b want 0/0/0/0/1",
               bl.out_valid, bl.out_data, bl.out_count, bl.words_out, bl.in_ready);
    end
    repeat (2) cycle();
    checks++;
    if (bm.out_valid !== 1'b0 || bl.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_flush_ignored got %b%b want 00", bm.out_valid, bl.out_valid);
    end
  endtask

  task automatic test_feed();
    int c;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 1'b0, c);
      checks++;
      if (c != 1) begin errors++; $display("FAIL feed_stall chunk %0d got %0d cycles want 1", i, c); end
      checks++;
      if (bm.out_valid !== (i == 8) || bl.out_valid !== (i == 8)) begin
        errors++; $display("FAIL feed_latency chunk %0d got %b%b want %b", i, bm.out_valid, bl.out_valid, i == 8);
      end
    end
    expect_word(8);
    checks++;
    if (bm.out_data !== 32'h12345678 || bl.out_data !== 32'h87654321) begin
      errors++; $display("FAIL feed_words got %h/%h want 12345678/87654321", bm.out_data, bl.out_data);
    end
    drain();
    checks++;
    if (bm.words_out !== exp_words || bl.words_out !== exp_words) begin
      errors++; $display("FAIL feed_words_out got %h/%h want %h", bm.words_out, bl.words_out, exp_words);
    end
  endtask

  task automatic test_stall();
    int c;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b0, c);
      if (i == 7 || i == 15) expect_word(8);
    end
    checks++;
    if (bm.in_ready !== 1'b0 || bl.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready got %b%b want 00", bm.in_ready, bl.in_ready);
    end
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (3) begin
      cycle();
      checks++;
      if (bm.out_data !== 32'h01234567 || bl.out_data !== 32'h76543210 || bm.out_count !== 4'd8) begin
        errors++; $display("FAIL stall_hold got %h/%h c=%h want 01234567/76543210 c=8",
                           bm.out_data, bl.out_data, bm.out_count);
      end
    end
    out_ready = 1'b1;
    send(4'h5, 1'b0, c);
    expect_word(1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drain();
    checks++;
    if (bm.words_out !== exp_words || bl.words_out !== exp_words) begin
      errors++; $display("FAIL stall_words_out got %h/%h want %h", bm.words_out, bl.words_out, exp_words);
    end
  endtask

  task automatic test_flush();
    int c;
    out_ready = 1'b1;
    send(4'hA, 1'b0, c);
    send(4'hB, 1'b0, c);
    send(4'hC, 1'b0, c);
    expect_word(3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (bm.out_data !== 32'hABC00000 || bl.out_data !== 32'h00000CBA || bm.out_count !== 4'd3) begin
      errors++; $display("FAIL flush_partial got %h/%h c=%h want ABC00000/00000CBA c=3",
                         bm.out_data, bl.out_data, bm.out_count);
    end
    drain();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (3) begin
      cycle();
      checks++;
      if (bm.out_valid !== 1'b0 || bl.out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_empty got %b%b want 00", bm.out_valid, bl.out_valid);
      end
    end
    send(4'hA, 1'b0, c);
    send(4'hB, 1'b0, c);
    send(4'hC, 1'b1, c);
    expect_word(3);
    checks++;
    if (bm.out_data !== 32'hABC00000 || bl.out_data !== 32'h00000CBA || bl.out_count !== 4'd3) begin
      errors++; $display("FAIL flush_same_cycle got %h/%h c=%h want ABC00000/00000CBA c=3",
                         bm.out_data, bl.out_data, bl.out_count);
    end
    drain();
    checks++;
    if (bm.words_out !== exp_words || bl.words_out !== exp_words) begin
      errors++; $display("FAIL flush_words_out got %h/%h want %h", bm.words_out, bl.words_out, exp_words);
    end
  endtask

  task automatic test_flush_stalled();
    int c;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, c);
    expect_word(8);
    send(4'h9, 1'b0, c);
    send(4'hA, 1'b0, c);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    expect_word(2);
    repeat (4) begin
      cycle();
      checks++;
      if (bm.out_data !== 32'h12345678 || bm.out_count !== 4'd8 || bm.out_valid !== 1'b1) begin
        errors++; $display("FAIL pend_hold got v=%b %h c=%h want 1 12345678 c=8",
                           bm.out_valid, bm.out_data, bm.out_count);
      end
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (bm.words_out !== exp_words || bl.words_out !== exp_words) begin
      errors++; $display("FAIL pend_words_out got %h/%h want %h", bm.words_out, bl.words_out, exp_words);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(4'(i), 1'b0, c);
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    sent.delete();
    exp_words = '0;
    checks++;
    if (bm.words_out !== 16'h0 || bm.out_valid !== 1'b0 || bl.words_out !== 16'h0) begin
      errors++; $display("FAIL mid_reset got w=%h v=%b want w=0 v=0", bm.words_out, bm.out_valid);
    end
    for (int i = 8; i <= 15; i++) send(4'(i), 1'b0, c);
    expect_word(8);
    checks++;
    if (bm.out_data !== 32'h89ABCDEF || bl.out_data !== 32'hFEDCBA98) begin
      errors++; $display("FAIL mid_reset_word got %h/%h want 89ABCDEF/FEDCBA98", bm.out_data, bl.out_data);
    end
    drain();
    checks++;
    if (bm.words_out !== 16'd1 || bl.words_out !== 16'd1) begin
      errors++; $display("FAIL mid_reset_words_out got %h/%h want 1", bm.words_out, bl.words_out);
    end
  endtask

  task automatic test_wrap();
    int c;
    force dut_m.words_cnt = 16'hFFFE;
    force dut_l.words_cnt = 16'hFFFE;
    #1;
    release dut_m.words_cnt;
    release dut_l.words_cnt;
    exp_words = 16'hFFFE;
    out_ready = 1'b1;
    send(4'h1, 1'b1, c);
    expect_word(1);
    drain();
    checks++;
    if (bm.words_out !== 16'hFFFF || bl.words_out !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_ffff got %h/%h want ffff", bm.words_out, bl.words_out);
    end
    send(4'h2, 1'b1, c);
    expect_word(1);
    drain();
    checks++;
    if (bm.words_out !== exp_words || bl.words_out !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got %h/%h want 0000", bm.words_out, bl.words_out);
    end
  endtask

  initial begin
    test_reset();
    test_feed();
    test_stall();
    test_flush();
    test_flush_stalled();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1);
  end

endmodule
